// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer
//   Generates the substitute 6502 clock from TED phi0 and the R/W relatch gate
//   for the 7501 bus bridge. While TED owns the bus (aec low), the CPU is held
//   in phi1 by stretching its clock low, so no CPU cycle overlaps a TED DMA
//   cycle. Skipped TED cycles are counted for debug.
// Ports
//   clk            fast system clock (>= 8x TED phi0), posedge logic
//   rst_n          async active-low reset
//   phi0_ted_i     TED phi0, asynchronous to clk
//   aec_i          TED address enable, low = TED owns bus, asynchronous
//   stall_clr_i    synchronous clear of stall_count_o
//   phi0_6502_o    registered clock to the 6502
//   gate_out_o     1 = bridge may relatch R/W (phi1), 0 = hold
//   cycle_end_o    one-clock pulse with each phi0_6502_o fall
//   stretching_o   1 while the CPU is held in a stretched phi1
//   stall_count_o  saturating count of skipped TED cycles
module cpu_phase_sequencer #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_LOW     = 3,
   parameter int unsigned MIN_HIGH    = 3,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 phi0_ted_i,
   input  logic                 aec_i,
   input  logic                 stall_clr_i,
   output logic                 phi0_6502_o,
   output logic                 gate_out_o,
   output logic                 cycle_end_o,
   output logic                 stretching_o,
   output logic [CNT_WIDTH-1:0] stall_count_o
);

   localparam int unsigned LO_W = $clog2(MIN_LOW + 1);
   localparam int unsigned HI_W = $clog2(MIN_HIGH + 1);

   typedef enum logic [1:0] {
      ST_PHI1    = 2'b00,
      ST_STRETCH = 2'b01,
      ST_PHI2    = 2'b10
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ted_sync_q, aec_sync_q;
   logic                   ted_dly_q;
   logic                   rise_pend_q, rise_pend_d;
   logic                   fall_pend_q, fall_pend_d;
   logic [LO_W-1:0]        lo_cnt_q, lo_cnt_d;
   logic [HI_W-1:0]        hi_cnt_q, hi_cnt_d;
   logic                   phi0_q, phi0_d;
   logic                   gate_q, gate_d;
   logic                   cycle_end_q, cycle_end_d;
   logic                   stretching_q, stretching_d;
   logic [CNT_WIDTH-1:0]   stall_q, stall_d;
   logic                   stall_inc;

   logic ted_s, aec_s, rise, fall, lo_ok, hi_ok;

   assign ted_s = ted_sync_q[SYNC_STAGES-1];
   assign aec_s = aec_sync_q[SYNC_STAGES-1];
   assign rise  = ted_s & ~ted_dly_q;
   assign fall  = ~ted_s & ted_dly_q;

   // Counters show clocks elapsed before the current one; comparing against
   // MIN-1 lets the phase end on the clock that completes its minimum width.
   assign lo_ok = (lo_cnt_q >= LO_W'(MIN_LOW - 1));
   assign hi_ok = (hi_cnt_q >= HI_W'(MIN_HIGH - 1));

   // Input synchronizers and edge-detect delay
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ted_sync_q <= '0;
         aec_sync_q <= '0;
         ted_dly_q  <= 1'b0;
      end else begin
         ted_sync_q <= {ted_sync_q[SYNC_STAGES-2:0], phi0_ted_i};
         aec_sync_q <= {aec_sync_q[SYNC_STAGES-2:0], aec_i};
         ted_dly_q  <= ted_s;
      end
   end

   // State, pending flags, phase counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_PHI1;
         rise_pend_q  <= 1'b0;
         fall_pend_q  <= 1'b0;
         lo_cnt_q     <= '0;
         hi_cnt_q     <= '0;
         phi0_q       <= 1'b0;
         gate_q       <= 1'b1;
         cycle_end_q  <= 1'b0;
         stretching_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         rise_pend_q  <= rise_pend_d;
         fall_pend_q  <= fall_pend_d;
         lo_cnt_q     <= lo_cnt_d;
         hi_cnt_q     <= hi_cnt_d;
         phi0_q       <= phi0_d;
         gate_q       <= gate_d;
         cycle_end_q  <= cycle_end_d;
         stretching_q <= stretching_d;
         stall_q      <= stall_d;
      end
   end

   // Next-state, pending-edge and output decode
   always_comb begin
      state_d     = state_q;
      rise_pend_d = rise_pend_q;
      fall_pend_d = fall_pend_q;
      stall_inc   = 1'b0;
      cycle_end_d = 1'b0;

      case (state_q)
         ST_PHI1: begin
            fall_pend_d = 1'b0;
            rise_pend_d = rise_pend_q | rise;
            if (rise_pend_q && lo_ok) begin
               if (aec_s) begin
                  state_d = ST_PHI2;
               end else begin
                  state_d   = ST_STRETCH;
                  stall_inc = 1'b1;
               end
            end
         end
         ST_STRETCH: begin
            // Low time is long satisfied here; every TED rise is a decision.
            fall_pend_d = 1'b0;
            rise_pend_d = rise_pend_q | rise;
            if (rise_pend_q) begin
               rise_pend_d = rise;
               if (aec_s) begin
                  state_d = ST_PHI2;
               end else begin
                  stall_inc = 1'b1;
               end
            end
         end
         ST_PHI2: begin
            // aec is deliberately ignored: an NMOS 6502 cannot pause in phi2.
            rise_pend_d = 1'b0;
            fall_pend_d = fall_pend_q | fall;
            if (fall_pend_q && hi_ok) begin
               state_d     = ST_PHI1;
               cycle_end_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_PHI1;
            rise_pend_d = 1'b0;
            fall_pend_d = 1'b0;
         end
      endcase

      // An edge arriving on a state change belongs to the phase being entered.
      if (state_d != state_q) begin
         rise_pend_d = rise & (state_d != ST_PHI2);
         fall_pend_d = fall & (state_d == ST_PHI2);
      end

      phi0_d       = (state_d == ST_PHI2);
      gate_d       = (state_d != ST_PHI2);
      stretching_d = (state_d == ST_STRETCH);
   end

   // Phase-width counters, cleared on each CPU clock transition
   always_comb begin
      lo_cnt_d = lo_cnt_q;
      hi_cnt_d = hi_cnt_q;
      if (phi0_d != phi0_q) begin
         lo_cnt_d = '0;
         hi_cnt_d = '0;
      end else if (!phi0_q) begin
         if (lo_cnt_q != LO_W'(MIN_LOW)) lo_cnt_d = lo_cnt_q + LO_W'(1);
      end else begin
         if (hi_cnt_q != HI_W'(MIN_HIGH)) hi_cnt_d = hi_cnt_q + HI_W'(1);
      end
   end

   // Saturating stall counter; clear beats a same-cycle increment
   always_comb begin
      stall_d = stall_q;
      if (stall_clr_i) begin
         stall_d = '0;
      end else if (stall_inc && (stall_q != {CNT_WIDTH{1'b1}})) begin
         stall_d = stall_q + CNT_WIDTH'(1);
      end
   end

   assign phi0_6502_o   = phi0_q;
   assign gate_out_o    = gate_q;
   assign cycle_end_o   = cycle_end_q;
   assign stretching_o  = stretching_q;
   assign stall_count_o = stall_q;

endmodule
